// File: rtl/generation_sequencer.sv
// Game of Life run-control sequencer: holds the grid in setup, then paces generation
// steps, counts them and stops on extinction, still life or a stalled step handshake.
module generation_sequencer #(
   parameter int TICK_DIV = 4,
   parameter int GEN_W    = 16,
   parameter int WDOG     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             startGameSwitch,
   input  logic             pauseSwitch,
   input  logic [1:0]       speed,
   input  logic             stepDone,
   input  logic             anyAlive,
   input  logic             gridChanged,
   output logic             setupEn,
   output logic             step,
   output logic [GEN_W-1:0] genCount,
   output logic             gameOver,
   output logic             stepError
);

   localparam int CW = $clog2(TICK_DIV * 8);
   localparam int WW = $clog2(WDOG + 1);

   typedef enum logic [2:0] {
      S_SETUP,
      S_WAIT,
      S_STEP,
      S_SETTLE,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     tick_q, tick_d;
   logic [WW-1:0]     wdog_q, wdog_d;
   logic [GEN_W-1:0]  gen_q, gen_d;
   logic              err_q, err_d;
   logic              setup_en_q, step_q, game_over_q;

   logic [CW:0]       period_full;
   logic [CW-1:0]     period_m1;

   // Counter only ever compares for equality, so a shorter period chosen while the
   // count is already past it lets the count roll over rather than stepping early.
   assign period_full = (CW+1)'(TICK_DIV) << (2'd3 - speed);
   assign period_m1   = CW'(period_full - (CW+1)'(1));

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      wdog_d  = wdog_q;
      gen_d   = gen_q;
      err_d   = err_q;
      case (state_q)
         S_SETUP: begin
            if (startGameSwitch) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (!startGameSwitch) begin
               state_d = S_SETUP;
            end else if (!pauseSwitch) begin
               if (tick_q == period_m1) begin
                  tick_d  = '0;
                  state_d = S_STEP;
               end else begin
                  tick_d = tick_q + CW'(1);
               end
            end
         end
         S_STEP: begin
            wdog_d  = '0;
            state_d = S_SETTLE;
         end
         S_SETTLE: begin
            // A handshake landing on the final watchdog cycle still counts as success.
            if (stepDone) begin
               if (gen_q != '1) gen_d = gen_q + GEN_W'(1);
               if (!anyAlive || !gridChanged) begin
                  state_d = S_DONE;
               end else begin
                  tick_d  = '0;
                  state_d = S_WAIT;
               end
            end else if (wdog_q == WW'(WDOG - 1)) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               wdog_d = wdog_q + WW'(1);
            end
         end
         S_DONE: begin
            if (!startGameSwitch) state_d = S_SETUP;
         end
         default: state_d = S_SETUP;
      endcase
      if (state_d == S_SETUP) begin
         tick_d = '0;
         wdog_d = '0;
         gen_d  = '0;
         err_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_SETUP;
         tick_q      <= '0;
         wdog_q      <= '0;
         gen_q       <= '0;
         err_q       <= 1'b0;
         setup_en_q  <= 1'b1;
         step_q      <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_q      <= tick_d;
         wdog_q      <= wdog_d;
         gen_q       <= gen_d;
         err_q       <= err_d;
         setup_en_q  <= (state_d == S_SETUP);
         step_q      <= (state_d == S_STEP);
         game_over_q <= (state_d == S_DONE);
      end
   end

   assign setupEn   = setup_en_q;
   assign step      = step_q;
   assign gameOver  = game_over_q;
   assign genCount  = gen_q;
   assign stepError = err_q;

endmodule

// File: tb/tb_generation_sequencer.sv
// Directed bench for generation_sequencer: step pacing, pause, speed change,
// game-over conditions, watchdog boundary and asynchronous reset.
module tb_generation_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        startGameSwitch = 1'b0;
   logic        pauseSwitch = 1'b0;
   logic [1:0]  speed = 2'd3;
   logic        stepDone = 1'b0;
   logic        anyAlive = 1'b0;
   logic        gridChanged = 1'b0;
   logic        setupEn;
   logic        step;
   logic [15:0] genCount;
   logic        gameOver;
   logic        stepError;

   int checks = 0;
   int passes = 0;

   generation_sequencer #(.TICK_DIV(4), .GEN_W(16), .WDOG(16)) dut (
      .clk            (clk),
      .reset          (reset),
      .startGameSwitch(startGameSwitch),
      .pauseSwitch    (pauseSwitch),
      .speed          (speed),
      .stepDone       (stepDone),
      .anyAlive       (anyAlive),
      .gridChanged    (gridChanged),
      .setupEn        (setupEn),
      .step           (step),
      .genCount       (genCount),
      .gameOver       (gameOver),
      .stepError      (stepError)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) begin
         passes++;
         $display("ok   %-22s got %0d", tag, got);
      end else begin
         $display("FAIL %-22s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Cycles until step is seen high, capped at limit.
   task automatic wait_step(input int limit, output int n);
      n = 0;
      while (!step && n < limit) begin
         cyc();
         n++;
      end
   endtask

   // Call while step is high: moves into SETTLE and delivers one stepDone.
   task automatic handshake(input logic alive, input logic changed);
      cyc();
      stepDone    = 1'b1;
      anyAlive    = alive;
      gridChanged = changed;
      cyc();
      stepDone = 1'b0;
   endtask

   initial begin
      int n;
      bit saw_step;

      // Reset state
      cyc(3);
      check("rst_setupEn", setupEn, 1);
      check("rst_step", step, 0);
      check("rst_gameOver", gameOver, 0);
      check("rst_genCount", genCount, 0);
      check("rst_stepError", stepError, 0);
      reset = 1'b0;
      cyc();

      // Fastest speed: first step after 4 WAIT cycles, one-cycle strobe
      startGameSwitch = 1'b1;
      cyc();
      check("t1_setupEn_fall", setupEn, 0);
      wait_step(50, n);
      check("t1_first_step_lat", n, 4);
      cyc();
      check("t1_step_one_cycle", step, 0);
      stepDone = 1'b1; anyAlive = 1'b1; gridChanged = 1'b1;
      cyc();
      stepDone = 1'b0;
      check("t1_genCount", genCount, 1);
      wait_step(50, n);
      check("t1_next_step_lat", n, 4);

      // Handshake on the 16th SETTLE cycle succeeds
      cyc(16);
      check("t5_edge_noover", gameOver, 0);
      stepDone = 1'b1; anyAlive = 1'b1; gridChanged = 1'b1;
      cyc();
      stepDone = 1'b0;
      check("t5_edge_gameOver", gameOver, 0);
      check("t5_edge_stepError", stepError, 0);
      check("t5_edge_genCount", genCount, 2);
      wait_step(50, n);
      check("t5_edge_back_wait", n, 4);

      // Withheld handshake: timeout after 16 SETTLE cycles
      cyc(16);
      check("t5_to_not_yet", gameOver, 0);
      cyc();
      check("t5_to_gameOver", gameOver, 1);
      check("t5_to_stepError", stepError, 1);
      check("t5_to_genCount", genCount, 2);
      startGameSwitch = 1'b0;
      cyc();
      check("t5_exit_setupEn", setupEn, 1);
      check("t5_exit_genCount", genCount, 0);
      check("t5_exit_stepError", stepError, 0);

      // Slowest speed, pause, then speed change past the new period
      speed = 2'd0;
      startGameSwitch = 1'b1;
      cyc();
      wait_step(100, n);
      check("t2_slow_lat", n, 32);
      handshake(1'b1, 1'b1);
      check("t2_genCount1", genCount, 1);
      cyc(10);
      pauseSwitch = 1'b1;
      cyc(10);
      pauseSwitch = 1'b0;
      wait_step(100, n);
      check("t2_pause_remaining", n, 22);
      handshake(1'b1, 1'b1);
      check("t2_genCount2", genCount, 2);
      cyc(10);
      speed = 2'd3;
      wait_step(100, n);
      check("t2_speed_wrap", n, 26);
      handshake(1'b1, 1'b1);
      check("t2_genCount3", genCount, 3);

      // Still life after three successful generations
      wait_step(50, n);
      check("t4_step_lat", n, 4);
      handshake(1'b1, 1'b0);
      check("t4_gameOver", gameOver, 1);
      check("t4_stepError", stepError, 0);
      check("t4_genCount", genCount, 4);
      startGameSwitch = 1'b0;
      cyc();
      check("t4_exit_genCount", genCount, 0);

      // Extinction on first generation; later stepDone ignored
      startGameSwitch = 1'b1;
      cyc();
      wait_step(50, n);
      handshake(1'b0, 1'b1);
      check("t3_gameOver", gameOver, 1);
      check("t3_stepError", stepError, 0);
      check("t3_genCount", genCount, 1);
      for (int i = 0; i < 3; i++) begin
         stepDone = 1'b1; anyAlive = 1'b1; gridChanged = 1'b1;
         cyc();
         stepDone = 1'b0;
         cyc();
      end
      check("t3_frozen_genCount", genCount, 1);
      startGameSwitch = 1'b0;
      cyc();
      check("t3_exit_setupEn", setupEn, 1);
      check("t3_exit_genCount", genCount, 0);

      // Async reset mid-SETTLE
      startGameSwitch = 1'b1;
      cyc();
      wait_step(50, n);
      handshake(1'b1, 1'b1);
      wait_step(50, n);
      cyc();
      check("t6_pre_genCount", genCount, 1);
      #2 reset = 1'b1;
      #1;
      check("t6_settle_setupEn", setupEn, 1);
      check("t6_settle_genCount", genCount, 0);
      check("t6_settle_gameOver", gameOver, 0);
      startGameSwitch = 1'b0;
      saw_step = 1'b0;
      cyc(2);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (step) saw_step = 1'b1;
      end
      check("t6_no_step_after_rst", saw_step, 0);

      // Async reset mid-WAIT
      startGameSwitch = 1'b1;
      cyc(3);
      check("t6_in_wait", setupEn, 0);
      #2 reset = 1'b1;
      #1;
      check("t6_wait_setupEn", setupEn, 1);
      check("t6_wait_step", step, 0);
      startGameSwitch = 1'b0;
      cyc(2);
      reset = 1'b0;
      cyc();

      // stepDone outside SETTLE ignored; leaving WAIT clears genCount
      startGameSwitch = 1'b1;
      cyc();
      wait_step(50, n);
      handshake(1'b1, 1'b1);
      stepDone = 1'b1; anyAlive = 1'b1; gridChanged = 1'b1;
      cyc();
      stepDone = 1'b0;
      check("t6_stray_done", genCount, 1);
      startGameSwitch = 1'b0;
      cyc();
      check("t6_abort_setupEn", setupEn, 1);
      check("t6_abort_genCount", genCount, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
